// File: rtl/com_identify_pkg.sv
// Shared definitions for the command-frame decoder: FSM encoding, command codes,
// header bytes and the frame checksum helper.
package com_identify_pkg;

   localparam int UART_FIFO_COUNTER_W = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_GAP   = 3'd2,
      ST_CHECK = 3'd3,
      ST_EXEC  = 3'd4,
      ST_RSTP  = 3'd5
   } state_e;

   localparam logic [7:0] CMD_SW_A  = 8'h01;
   localparam logic [7:0] CMD_SW_B  = 8'h02;
   localparam logic [7:0] CMD_RST_A = 8'h03;
   localparam logic [7:0] CMD_RST_B = 8'h04;
   localparam logic [7:0] CMD_FWD   = 8'h10;

   localparam logic [7:0] HDR0_DEF = 8'hEB;
   localparam logic [7:0] HDR1_DEF = 8'h90;

   function automatic logic [7:0] frame_sum(input logic [7:0] cmd, input logic [7:0] param);
      return cmd + param;
   endfunction

   function automatic logic cmd_known(input logic [7:0] cmd);
      logic known;
      case (cmd)
         CMD_SW_A, CMD_SW_B, CMD_RST_A, CMD_RST_B, CMD_FWD: known = 1'b1;
         default: known = 1'b0;
      endcase
      return known;
   endfunction

endpackage

// File: rtl/com_identify.sv
// Command-frame decoder: drains one frame from the selected receive FIFO, validates it
// and drives the switch controls, CPU reset pulses or the forwarded UART byte.
module com_identify
   import com_identify_pkg::*;
#(
   parameter int unsigned FRAME_LEN  = 5,
   parameter logic [15:0] RST_CYCLES = 16'd50000,
   parameter logic [7:0]  HDR0       = HDR0_DEF,
   parameter logic [7:0]  HDR1       = HDR1_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [7:0]                     rec_command,
   input  logic [UART_FIFO_COUNTER_W-1:0] com_count,
   input  logic                           command_time_out,
   output logic                           com_pop,
   output logic [7:0]                     tdr_cpuAB,
   output logic                           tf_push_cpuAB,
   output logic                           force_swi,
   output logic                           com_swi,
   output logic                           error,
   output logic                           reset_A,
   output logic                           reset_B
);

   localparam int CW = UART_FIFO_COUNTER_W;
   localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);

   state_e          state_q, state_d;
   logic [CW-1:0]   n_q, n_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [7:0]      frame_q [FRAME_LEN];
   logic [7:0]      frame_d [FRAME_LEN];
   logic [15:0]     cnt_q, cnt_d;
   logic            com_pop_q, com_pop_d;
   logic [7:0]      tdr_q, tdr_d;
   logic            push_q, push_d;
   logic            force_q, force_d;
   logic            com_swi_q, com_swi_d;
   logic            error_q, error_d;
   logic            reset_a_q, reset_a_d;
   logic            reset_b_q, reset_b_d;
   logic            frame_ok_s;
   logic [7:0]      cmd_s;
   logic [7:0]      param_s;

   assign cmd_s   = frame_q[2];
   assign param_s = frame_q[3];

   // Frame acceptance: exact length, both headers, checksum and a known command.
   always_comb begin
      frame_ok_s = (n_q == FRAME_LEN_C) && (frame_q[0] == HDR0) && (frame_q[1] == HDR1) &&
                   (frame_q[FRAME_LEN-1] == frame_sum(cmd_s, param_s)) && cmd_known(cmd_s);
   end

   // Next-state and registered-output computation; pulses default low, levels hold.
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      idx_d     = idx_q;
      frame_d   = frame_q;
      cnt_d     = cnt_q;
      com_pop_d = 1'b0;
      push_d    = 1'b0;
      force_d   = 1'b0;
      tdr_d     = tdr_q;
      com_swi_d = com_swi_q;
      error_d   = error_q;
      reset_a_d = reset_a_q;
      reset_b_d = reset_b_q;
      case (state_q)
         ST_IDLE: begin
            if (command_time_out && (com_count != {CW{1'b0}})) begin
               n_d       = com_count;
               idx_d     = {CW{1'b0}};
               com_pop_d = 1'b1;
               state_d   = ST_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            // Bytes beyond the frame length are popped but not stored.
            for (int i = 0; i < int'(FRAME_LEN); i++) begin
               if (idx_q == CW'(i)) begin
                  frame_d[i] = rec_command;
               end else begin
                  frame_d[i] = frame_q[i];
               end
            end
            idx_d   = idx_q + CW'(1);
            state_d = ST_GAP;
         end
         ST_GAP: begin
            if (idx_q < n_q) begin
               com_pop_d = 1'b1;
               state_d   = ST_READ;
            end else begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (frame_ok_s) begin
               error_d = 1'b0;
               state_d = ST_EXEC;
               case (cmd_s)
                  CMD_SW_A: begin
                     com_swi_d = 1'b0;
                     force_d   = 1'b1;
                  end
                  CMD_SW_B: begin
                     com_swi_d = 1'b1;
                     force_d   = 1'b1;
                  end
                  CMD_RST_A: begin
                     reset_a_d = 1'b1;
                     cnt_d     = RST_CYCLES;
                  end
                  CMD_RST_B: begin
                     reset_b_d = 1'b1;
                     cnt_d     = RST_CYCLES;
                  end
                  CMD_FWD: begin
                     tdr_d  = param_s;
                     push_d = 1'b1;
                  end
                  default: state_d = ST_IDLE;
               endcase
            end else begin
               error_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_EXEC, ST_RSTP: begin
            // The EXEC cycle is the first cycle of a reset pulse.
            if ((state_q == ST_RSTP) || (cmd_s == CMD_RST_A) || (cmd_s == CMD_RST_B)) begin
               cnt_d = cnt_q - 16'd1;
               if (cnt_q <= 16'd1) begin
                  reset_a_d = 1'b0;
                  reset_b_d = 1'b0;
                  state_d   = ST_IDLE;
               end else begin
                  state_d = ST_RSTP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         n_q       <= {CW{1'b0}};
         idx_q     <= {CW{1'b0}};
         for (int i = 0; i < int'(FRAME_LEN); i++) begin
            frame_q[i] <= 8'h00;
         end
         cnt_q     <= 16'd0;
         com_pop_q <= 1'b0;
         tdr_q     <= 8'h00;
         push_q    <= 1'b0;
         force_q   <= 1'b0;
         com_swi_q <= 1'b0;
         error_q   <= 1'b0;
         reset_a_q <= 1'b0;
         reset_b_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         idx_q     <= idx_d;
         frame_q   <= frame_d;
         cnt_q     <= cnt_d;
         com_pop_q <= com_pop_d;
         tdr_q     <= tdr_d;
         push_q    <= push_d;
         force_q   <= force_d;
         com_swi_q <= com_swi_d;
         error_q   <= error_d;
         reset_a_q <= reset_a_d;
         reset_b_q <= reset_b_d;
      end
   end

   assign com_pop       = com_pop_q;
   assign tdr_cpuAB     = tdr_q;
   assign tf_push_cpuAB = push_q;
   assign force_swi     = force_q;
   assign com_swi       = com_swi_q;
   assign error         = error_q;
   assign reset_A       = reset_a_q;
   assign reset_B       = reset_b_q;

endmodule

// File: tb/tb_com_identify.sv
// Self-checking bench for com_identify: a FIFO stand-in, a frame-level timing model
// checked every cycle, and directed frames with hand-computed expectations.
module tb_com_identify;
   import com_identify_pkg::*;

   localparam int MAXC = 2000;
   localparam int RSTC = 4;

   logic                           clk = 1'b0;
   logic                           rst_n;
   logic [7:0]                     rec_command;
   logic [UART_FIFO_COUNTER_W-1:0] com_count;
   logic                           command_time_out;
   logic                           com_pop, tf_push_cpuAB, force_swi, com_swi, error, reset_A, reset_B;
   logic [7:0]                     tdr_cpuAB;

   com_identify #(.FRAME_LEN(5), .RST_CYCLES(16'd4), .HDR0(8'hEB), .HDR1(8'h90)) dut (
      .clk(clk), .rst_n(rst_n), .rec_command(rec_command), .com_count(com_count),
      .command_time_out(command_time_out), .com_pop(com_pop), .tdr_cpuAB(tdr_cpuAB),
      .tf_push_cpuAB(tf_push_cpuAB), .force_swi(force_swi), .com_swi(com_swi),
      .error(error), .reset_A(reset_A), .reset_B(reset_B)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   byte unsigned fifo[$];

   // frame-level model: per-cycle expected pulses plus level updates at the exec cycle
   bit exp_pop[MAXC], exp_force[MAXC], exp_push[MAXC], exp_rsta[MAXC], exp_rstb[MAXC];
   int free_at = 0;
   int ev_t = -1;
   bit ev_valid, ev_set_swi, ev_swi, ev_set_tdr;
   byte unsigned ev_tdr;
   bit m_swi = 1'b0, m_err = 1'b0;
   byte unsigned m_tdr = 8'h00;

   int pop_cnt = 0, push_cnt = 0, force_cnt = 0, rsta_cnt = 0, rstb_cnt = 0, pop_in_rst = 0;
   int pop_cyc[$];
   int force_cyc = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
      end
   endfunction

   function automatic void schedule(int c, int n);
      byte unsigned b[$];
      int e;
      bit valid;
      for (int j = 0; j < n; j++) begin
         b.push_back((j < fifo.size()) ? fifo[j] : 8'h00);
         if (c + 1 + 2*j < MAXC) exp_pop[c + 1 + 2*j] = 1'b1;
      end
      e = c + 2*n + 2;
      valid = (n == 5) && (b[0] == 8'hEB) && (b[1] == 8'h90) &&
              (((int'(b[2]) + int'(b[3])) % 256) == int'(b[4])) &&
              (b[2] == 8'h01 || b[2] == 8'h02 || b[2] == 8'h03 || b[2] == 8'h04 || b[2] == 8'h10);
      ev_t = e; ev_valid = valid; ev_set_swi = 1'b0; ev_set_tdr = 1'b0;
      free_at = e;
      if (valid && e + RSTC < MAXC) begin
         free_at = e + 1;
         if (b[2] == 8'h01 || b[2] == 8'h02) begin
            ev_set_swi = 1'b1; ev_swi = (b[2] == 8'h02); exp_force[e] = 1'b1;
         end else if (b[2] == 8'h10) begin
            ev_set_tdr = 1'b1; ev_tdr = b[3]; exp_push[e] = 1'b1;
         end else begin
            for (int r = 0; r < RSTC; r++) begin
               if (b[2] == 8'h03) exp_rsta[e + r] = 1'b1;
               else exp_rstb[e + r] = 1'b1;
            end
            free_at = e + RSTC;
         end
      end
   endfunction

   // FIFO stand-in: pop the head on each sampled com_pop, present head/count mid-cycle
   always @(posedge clk) if (com_pop === 1'b1 && fifo.size() > 0) void'(fifo.pop_front());
   always @(negedge clk) begin
      com_count   = UART_FIFO_COUNTER_W'(fifo.size());
      rec_command = (fifo.size() > 0) ? fifo[0] : 8'h00;
   end

   // compare process: update model, then check every output each cycle
   always @(posedge clk) begin
      #1;
      cyc++;
      if (cyc < MAXC) begin
         if (rst_n !== 1'b1) begin
            for (int i = cyc; i < MAXC; i++) begin
               exp_pop[i] = 1'b0; exp_force[i] = 1'b0; exp_push[i] = 1'b0;
               exp_rsta[i] = 1'b0; exp_rstb[i] = 1'b0;
            end
            m_swi = 1'b0; m_err = 1'b0; m_tdr = 8'h00; ev_t = -1; free_at = cyc;
         end else begin
            if (free_at <= cyc - 1 && command_time_out === 1'b1 && int'(com_count) != 0)
               schedule(cyc - 1, int'(com_count));
            if (cyc == ev_t) begin
               m_err = !ev_valid;
               if (ev_set_swi) m_swi = ev_swi;
               if (ev_set_tdr) m_tdr = ev_tdr;
            end
         end
         chk("com_pop",   32'(com_pop),       32'(exp_pop[cyc]));
         chk("force_swi", 32'(force_swi),     32'(exp_force[cyc]));
         chk("tf_push",   32'(tf_push_cpuAB), 32'(exp_push[cyc]));
         chk("reset_A",   32'(reset_A),       32'(exp_rsta[cyc]));
         chk("reset_B",   32'(reset_B),       32'(exp_rstb[cyc]));
         chk("com_swi",   32'(com_swi),       32'(m_swi));
         chk("error",     32'(error),         32'(m_err));
         chk("tdr_cpuAB", 32'(tdr_cpuAB),     32'(m_tdr));
      end
      if (com_pop === 1'b1) begin
         pop_cnt++; pop_cyc.push_back(cyc);
         if (reset_A === 1'b1 || reset_B === 1'b1) pop_in_rst++;
      end
      if (tf_push_cpuAB === 1'b1) push_cnt++;
      if (force_swi === 1'b1) begin force_cnt++; force_cyc = cyc; end
      if (reset_A === 1'b1) rsta_cnt++;
      if (reset_B === 1'b1) rstb_cnt++;
   end

   task automatic load5(input byte unsigned a, input byte unsigned b, input byte unsigned c,
                        input byte unsigned d, input byte unsigned e);
      fifo.push_back(a); fifo.push_back(b); fifo.push_back(c); fifo.push_back(d); fifo.push_back(e);
   endtask

   task automatic wait_quiet(input int budget);
      int n = 0;
      repeat (3) @(negedge clk);
      while (!(fifo.size() == 0 && free_at <= cyc && ev_t < cyc) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("quiet_budget", 32'(n < budget), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic fire(input int budget);
      @(negedge clk);
      command_time_out = 1'b1;
      wait_quiet(budget);
      command_time_out = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, f0, u0, ra0, rb0, n;
      rst_n = 1'b0; command_time_out = 1'b0; rec_command = 8'h00; com_count = '0;
      repeat (3) @(negedge clk);
      chk("reset_state", {23'd0, com_pop, tf_push_cpuAB, force_swi, com_swi, error, reset_A, reset_B, 1'b0},
          32'd0);
      chk("reset_tdr", 32'(tdr_cpuAB), 32'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // switch to B
      p0 = pop_cnt; f0 = force_cnt; pop_cyc.delete();
      load5(8'hEB, 8'h90, 8'h02, 8'h00, 8'h02);
      fire(100);
      chk("f1_pops", 32'(pop_cnt - p0), 32'd5);
      chk("f1_force", 32'(force_cnt - f0), 32'd1);
      chk("f1_swi", 32'(com_swi), 32'd1);
      chk("f1_err", 32'(error), 32'd0);
      chk("f1_pop_span", 32'(pop_cyc[4] - pop_cyc[0]), 32'd8);
      chk("f1_exec_lat", 32'(force_cyc - pop_cyc[0]), 32'd11);

      // forward a byte
      u0 = push_cnt; f0 = force_cnt;
      load5(8'hEB, 8'h90, 8'h10, 8'h5A, 8'h6A);
      fire(100);
      chk("f2_push", 32'(push_cnt - u0), 32'd1);
      chk("f2_tdr", 32'(tdr_cpuAB), 32'h5A);
      chk("f2_force", 32'(force_cnt - f0), 32'd0);
      chk("f2_swi", 32'(com_swi), 32'd1);

      // reset A, with a reset-B frame queued during the pulse
      ra0 = rsta_cnt; rb0 = rstb_cnt; p0 = pop_cnt; pop_in_rst = 0;
      load5(8'hEB, 8'h90, 8'h03, 8'h00, 8'h03);
      @(negedge clk);
      command_time_out = 1'b1;
      n = 0;
      while (reset_A !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("f3_rsta_seen", 32'(reset_A), 32'd1);
      load5(8'hEB, 8'h90, 8'h04, 8'h00, 8'h04);
      wait_quiet(200);
      command_time_out = 1'b0;
      chk("f3_rsta_width", 32'(rsta_cnt - ra0), 32'd4);
      chk("f3_rstb_width", 32'(rstb_cnt - rb0), 32'd4);
      chk("f3_pop_in_rst", 32'(pop_in_rst), 32'd0);
      chk("f3_pops", 32'(pop_cnt - p0), 32'd10);

      // bad checksum, then a good switch-to-A
      f0 = force_cnt; p0 = pop_cnt;
      load5(8'hEB, 8'h90, 8'h01, 8'h00, 8'h07);
      fire(100);
      chk("f4_pops", 32'(pop_cnt - p0), 32'd5);
      chk("f4_err", 32'(error), 32'd1);
      chk("f4_force", 32'(force_cnt - f0), 32'd0);
      load5(8'hEB, 8'h90, 8'h01, 8'h00, 8'h01);
      fire(100);
      chk("f5_err", 32'(error), 32'd0);
      chk("f5_swi", 32'(com_swi), 32'd0);

      // oversize burst
      p0 = pop_cnt;
      load5(8'hEB, 8'h90, 8'h01, 8'h00, 8'h01);
      fifo.push_back(8'hAA); fifo.push_back(8'hBB);
      fire(100);
      chk("f6_pops", 32'(pop_cnt - p0), 32'd7);
      chk("f6_err", 32'(error), 32'd1);
      chk("f6_fifo_empty", 32'(fifo.size()), 32'd0);

      // reset asserted after the second pop of a valid frame
      p0 = pop_cnt;
      load5(8'hEB, 8'h90, 8'h02, 8'h00, 8'h02);
      @(negedge clk);
      command_time_out = 1'b1;
      n = 0;
      while (pop_cnt < p0 + 2 && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("f7_outs_zero", {24'd0, com_pop, tf_push_cpuAB, force_swi, com_swi, error, reset_A, reset_B, 1'b0},
          32'd0);
      chk("f7_fifo_left", 32'(fifo.size()), 32'd3);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_quiet(100);
      command_time_out = 1'b0;
      chk("f7_err", 32'(error), 32'd1);
      chk("f7_pops", 32'(pop_cnt - p0), 32'd5);
      chk("f7_fifo_empty", 32'(fifo.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/com_identify.md
# com_identify

Command-frame decoder for the dual-CPU switch. It consumes the command bytes that the switch core collects from comm port A or B: it reads the selected receive FIFO through `rec_command`/`com_count`/`com_pop`. Each complete frame is validated. Valid frames drive the core's switch controls (`force_swi`, `com_swi`, `reset_A`, `reset_B`, `error`) or forward a data byte to both CPU UART transmit FIFOs (`tdr_cpuAB`/`tf_push_cpuAB`).

## Interface
Parameters:
- `FRAME_LEN`, 5: bytes per command frame.
- `RST_CYCLES`, 16'd50000: width of a `reset_A`/`reset_B` pulse, in clk cycles (must be ≥1).
- `HDR0`, 8'hEB: first header byte.
- `HDR1`, 8'h90: second header byte.

Ports (one clock; reset is asynchronous and active-low, ports `clk` and `rst_n`):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rec_command`  in  8  head byte of the selected receive FIFO, valid while `com_count`≠0.
- `com_count`  in  `UART_FIFO_COUNTER_W`  byte count in the selected FIFO.
- `command_time_out`  in  1  both links idle for the frame gap; the frame is complete.
- `com_pop`  out  1  one-cycle pop of the FIFO head.
- `tdr_cpuAB`  out  8  byte sent to both CPU UARTs.
- `tf_push_cpuAB`  out  1  one-cycle push qualifying `tdr_cpuAB`.
- `force_swi`  out  1  one-cycle forced-switch strobe.
- `com_swi`  out  1  commanded target CPU: 0=A, 1=B (level).
- `error`  out  1  last frame rejected (level).
- `reset_A`  out  1  reset pulse to CPU A.
- `reset_B`  out  1  reset pulse to CPU B.

## Operation
- Frame format: `HDR0`, `HDR1`, CMD, PARAM, SUM. SUM = (CMD+PARAM) mod 256.
- Commands:
  - 8'h01: `com_swi`←0, `force_swi` pulse.
  - 8'h02: `com_swi`←1, `force_swi` pulse.
  - 8'h03: `reset_A` pulse.
  - 8'h04: `reset_B` pulse.
  - 8'h10: push PARAM to `tdr_cpuAB`.
  - Any other CMD is invalid.
- FSM states: IDLE, READ, GAP, CHECK, EXEC, RSTP.
- IDLE: when `command_time_out`=1 and `com_count`≠0, snapshot `n`=`com_count`, clear the byte index, go to READ.
- READ: capture `rec_command` into buf[idx] (only if idx<FRAME_LEN), assert `com_pop`, idx++, go to GAP.
- GAP: one idle cycle so the FIFO head can update. Then go to READ if idx<n, otherwise to CHECK.
- CHECK: the frame is valid only if n==FRAME_LEN, headers match, SUM matches, and CMD is known.
  - Invalid: `error`←1, return to IDLE.
  - Valid: `error`←0, go to EXEC.
- EXEC: perform the command for one cycle. 8'h03/8'h04 go to RSTP; all others return to IDLE.
- RSTP: hold the selected reset high for `RST_CYCLES` cycles using a 16-bit down-counter, then return to IDLE. Frames are not consumed while in RSTP.
- Oversize or undersize frames are drained completely (all `n` bytes popped) and then flagged.
- The snapshot `n` is authoritative. A deassertion of `command_time_out` or a change in `com_count` mid-frame does not abort the read.
- Only one of `reset_A`/`reset_B` is ever high at a time.

## Timing
- Reset values:
  - `com_pop`, `tf_push_cpuAB`, `force_swi`, `reset_A`, `reset_B`, `error`, `com_swi`: 0.
  - `tdr_cpuAB`: 8'h00.
  - FSM: IDLE.
- All outputs are registered.
- Read cost: 2 cycles per byte. For a 5-byte frame the last `com_pop` occurs 9 cycles after the IDLE trigger cycle, CHECK follows 2 cycles later, and the EXEC outputs appear the cycle after that.
- `force_swi` and `tf_push_cpuAB` are exactly 1 cycle wide. `com_swi` changes in the same cycle that `force_swi` rises.
- `tdr_cpuAB` is stable in the cycle `tf_push_cpuAB`=1 and holds afterwards.
- `rst_n` asserted mid-frame: immediate return to IDLE with outputs at reset values. Bytes already popped are lost, and the remaining bytes are treated as a new frame.

## Structure
- `com_identify_pkg` (or a shared `define` include beside `uart_defines.v`) holds:
  - the state encoding;
  - the command codes CMD_SW_A, CMD_SW_B, CMD_RST_A, CMD_RST_B, CMD_FWD;
  - the HDR constants.
- `UART_FIFO_COUNTER_W` comes from `uart_defines.v`.
- No sub-modules. The reset pulse counter stays inline.

## Test plan
- Stream EB 90 02 00 02 with `command_time_out`=1 → 5 `com_pop` pulses spaced 2 cycles apart, `com_swi`=1, one `force_swi` pulse, `error`=0.
- Frame EB 90 10 5A 6A → a single `tf_push_cpuAB` with `tdr_cpuAB`=8'h5A; the switch outputs stay unchanged.
- Frame EB 90 03 00 03 with `RST_CYCLES`=4 → `reset_A` high for exactly 4 cycles; a second frame queued during the pulse is popped only afterwards.
- Bad checksum EB 90 01 00 07 → 5 pops, `error`=1, no `force_swi`. A following valid 01 frame → `error`=0, `com_swi`=0.
- Seven-byte burst EB 90 01 00 01 AA BB → 7 pops, `error`=1, FIFO empty at the end.
- `rst_n` pulsed low after the 2nd pop of a valid frame → all outputs 0. The remaining 3 bytes are then read as a 3-byte frame and give `error`=1.
